rr_arb_mux: RTL

//   Parametrised N-channel registered multiplexer with valid/ready handshake on every port.

---
 rtl/rr_arb_mux.sv | 71 +++++++
 1 files changed

// File: rtl/rr_arb_mux.sv
// N-channel registered mux with valid/ready on every port.
// One beat per clock moves from the granted input channel into a single output register.
module rr_arb_mux #(
    parameter  int N_CH      = 4,
    parameter  int WIDTH     = 8,
    parameter  bit PRIO_MODE = 1'b0,
    localparam int SELW      = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SELW-1:0]       out_sel,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [N_CH-1:0][WIDTH-1:0] ch_data;
    logic [SELW-1:0]            rr_ptr;
    logic [SELW-1:0]            start;
    logic [SELW-1:0]            gidx;
    logic [N_CH-1:0]            grant;
    logic                       found;
    logic                       load_en;

    assign ch_data = in_data;
    assign load_en = !out_valid || out_ready;

    // Fixed priority is the round-robin search with the pointer pinned to the last channel.
    assign start = PRIO_MODE ? SELW'(N_CH - 1) : rr_ptr;

    always_comb begin
        int idx;
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = (int'(start) + k) % N_CH;
            if (!found && in_valid[idx]) begin
                grant[idx] = 1'b1;
                gidx       = SELW'(idx);
                found      = 1'b1;
            end
        end
    end

    // Gated by rst_n so no channel sees a handshake while reset is held.
    assign in_ready = (rst_n && load_en) ? grant : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            rr_ptr    <= SELW'(N_CH - 1);
        end else if (load_en) begin
            if (found) begin
                out_valid <= 1'b1;
                out_data  <= ch_data[gidx];
                out_sel   <= gidx;
                if (!PRIO_MODE) rr_ptr <= gidx;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
